// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit in front of a 32-bit,
// single-write-enable synchronous data memory (sub-word stores use RMW).
module dmem_lsu #(
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W+1:0] i_req_addr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              req_err;
    logic [4:0]        shamt;
    logic [15:0]       lane_data;
    logic [31:0]       lane_mask;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    always_comb begin
        req_err = (i_req_size == 2'b11)
                | ((i_req_size == 2'b01) & i_req_addr[0])
                | ((i_req_size == 2'b10) & (|i_req_addr[1:0]));
    end

    // Lane extraction and merge share one shift; aligned halves have lane[0]=0.
    always_comb begin
        shamt     = {lane_q, 3'b000};
        lane_data = 16'(i_mem_rdata >> shamt);
        unique case (size_q)
            2'b00: begin
                lane_mask = 32'h0000_00FF << shamt;
                load_val  = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF << shamt;
                load_val  = {{16{~uns_q & lane_data[15]}}, lane_data};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                load_val  = i_mem_rdata;
            end
        endcase
        merged = (i_mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        addr_d      = addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        wren_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid && ready_q) begin
                    we_d        = i_req_we;
                    size_d      = i_req_size;
                    uns_d       = i_req_unsigned;
                    lane_d      = i_req_addr[1:0];
                    wdata_d     = i_req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = req_err;
                    if (req_err) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        addr_d = i_req_addr[ADDR_W+1:2];
                        if (i_req_we && (i_req_size == 2'b10)) begin
                            state_d     = S_WR;
                            wren_d      = 1'b1;
                            mem_wdata_d = i_req_wdata;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (we_q) begin
                    state_d     = S_WR;
                    wren_d      = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_val;
                end
            end
            S_WR: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_wren  = wren_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: table vectors, reset-abort and back-to-back sequences, and a
// random request stream checked against a byte-level memory model.
module tb_dmem_lsu;
    localparam int AW = 13;
    localparam int NW = 1 << AW;

    typedef struct {
        logic          we;
        logic [AW+1:0] addr;
        logic [1:0]    size;
        logic          uns;
        logic [31:0]   wdata;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } rsp_t;

    typedef struct {
        req_t        r;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready, req_we, req_uns;
    logic [AW+1:0] req_addr;
    logic [1:0]    req_size;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_clr;
    logic [31:0]   mem [NW];
    logic [31:0]   ref_mem [NW];
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < NW; i++) mem[i] <= '0;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    dmem_lsu #(.ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_size(req_size), .i_req_unsigned(req_uns),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err),
        .o_mem_wren(mem_wren), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-array view of memory: stores copy bytes, loads shift and extend.
    function automatic rsp_t model(input req_t r);
        rsp_t o;
        int nb, off, w;
        logic [31:0] word, v, mask;
        nb = 1 << r.size;
        off = int'(r.addr % 4);
        w = int'(r.addr / 4);
        o.rdata = '0;
        o.err = 1'b0;
        if (r.size == 2'd3 || (off % nb) != 0) begin
            o.err = 1'b1;
            o.lat = 1;
            return o;
        end
        word = ref_mem[w];
        if (r.we) begin
            for (int i = 0; i < nb; i++)
                word[8*(off+i) +: 8] = r.wdata[8*i +: 8];
            ref_mem[w] = word;
            o.lat = (nb == 4) ? 2 : 4;
        end else begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8*nb)) - 1;
            v = (word >> (8*off)) & mask;
            if (!r.uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
            o.rdata = v;
            o.lat = 3;
        end
        return o;
    endfunction

    function automatic req_t mkr(input logic we, input logic [AW+1:0] a,
                                 input logic [1:0] sz, input logic u,
                                 input logic [31:0] wd);
        req_t r;
        r.we = we; r.addr = a; r.size = sz; r.uns = u; r.wdata = wd;
        return r;
    endfunction

    function automatic vec_t mk(input logic we, input logic [AW+1:0] a,
                                input logic [1:0] sz, input logic u,
                                input logic [31:0] wd, input logic e,
                                input logic [31:0] rd, input int lat);
        vec_t v;
        v.r = mkr(we, a, sz, u, wd);
        v.err = e; v.rdata = rd; v.lat = lat;
        return v;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int w, off;
        w = ($urandom_range(0, 7) == 0) ? NW - 1 : int'($urandom_range(0, 15));
        r.we = 1'($urandom_range(0, 1));
        r.size = 2'($urandom_range(0, 3));
        r.uns = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        off = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) off = off & ~((1 << r.size) - 1);
        r.addr = (AW+2)'(w * 4 + off);
        return r;
    endfunction

    task automatic drive(input req_t r);
        req_we = r.we;
        req_addr = r.addr;
        req_size = r.size;
        req_uns = r.uns;
        req_wdata = r.wdata;
    endtask

    task automatic do_req(input req_t r, output logic err,
                          output logic [31:0] rd, output int lat,
                          output int wr);
        @(negedge clk);
        chk("ready_before_req", 32'(req_ready), 32'd1);
        drive(r);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        drive(rand_req());
        lat = 0; wr = 0; err = 1'b0; rd = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_wren) wr++;
            if (rsp_valid) begin
                lat = k; err = rsp_err; rd = rsp_rdata;
                break;
            end
        end
    endtask

    // Valid stays high; stray fields are presented whenever the unit is busy.
    task automatic run_stream(input req_t q[$], input string tag);
        int idx = 0, age = 0, cyc = 0;
        logic busy = 1'b0, e_wr = 1'b0;
        rsp_t e;
        e.err = 1'b0; e.rdata = '0; e.lat = 0;
        while ((idx < q.size() || busy) && cyc < 10 * q.size() + 20) begin
            @(negedge clk);
            cyc++;
            if (busy) age++;
            chk({tag, "_ready"}, 32'(req_ready), 32'(!busy));
            chk({tag, "_rsp_valid"}, 32'(rsp_valid),
                32'(busy && age == e.lat));
            chk({tag, "_wren"}, 32'(mem_wren),
                32'(busy && e_wr && age == e.lat - 1));
            if (busy && age == e.lat) begin
                chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
                chk({tag, "_rdata"}, rsp_rdata, e.rdata);
                busy = 1'b0;
                drive(rand_req());
                req_valid = (idx < q.size());
            end else if (!busy) begin
                drive(q[idx]);
                req_valid = 1'b1;
                e = model(q[idx]);
                e_wr = q[idx].we && !e.err;
                idx++;
                busy = 1'b1;
                age = 0;
            end else begin
                drive(rand_req());
                req_valid = 1'b1;
            end
        end
        if (busy || idx < q.size())
            chk({tag, "_timeout"}, 32'(idx), 32'(q.size() + 1));
        req_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        req_t q[$];
        rsp_t rs;
        logic err;
        logic [31:0] rd;
        int lat, wr;

        req_valid = 1'b0;
        drive(mkr(1'b0, '0, 2'd0, 1'b0, '0));
        mem_clr = 1'b1;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;

        tbl.push_back(mk(1, 'h0000, 2, 0, 'hA5A5A5A5, 0, 0, 2));
        tbl.push_back(mk(0, 'h0000, 2, 0, 0, 0, 'hA5A5A5A5, 3));
        tbl.push_back(mk(1, 'h0004, 2, 0, 'h12345678, 0, 0, 2));
        tbl.push_back(mk(1, 'h0006, 0, 0, 'h123456EE, 0, 0, 4));
        tbl.push_back(mk(0, 'h0004, 2, 0, 0, 0, 'h12EE5678, 3));
        tbl.push_back(mk(0, 'h0006, 0, 0, 0, 0, 'hFFFFFFEE, 3));
        tbl.push_back(mk(0, 'h0006, 0, 1, 0, 0, 'h000000EE, 3));
        tbl.push_back(mk(0, 'h0005, 0, 0, 0, 0, 'h00000056, 3));
        tbl.push_back(mk(1, 'h0008, 2, 0, 'h5A5A5A5A, 0, 0, 2));
        tbl.push_back(mk(1, 'h000A, 1, 0, 'hFFFF8001, 0, 0, 4));
        tbl.push_back(mk(0, 'h0008, 2, 0, 0, 0, 'h80015A5A, 3));
        tbl.push_back(mk(0, 'h000A, 1, 0, 0, 0, 'hFFFF8001, 3));
        tbl.push_back(mk(0, 'h000A, 1, 1, 0, 0, 'h00008001, 3));
        tbl.push_back(mk(0, 'h0002, 2, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 'h0003, 1, 0, 'h0000BEEF, 1, 0, 1));
        tbl.push_back(mk(0, 'h0000, 3, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 'h0000, 3, 0, 'h11111111, 1, 0, 1));
        tbl.push_back(mk(0, 'h0000, 2, 0, 0, 0, 'hA5A5A5A5, 3));
        tbl.push_back(mk(1, 'h7FFC, 2, 0, 'hCAFEF00D, 0, 0, 2));
        tbl.push_back(mk(0, 'h7FFF, 0, 1, 0, 0, 'h000000CA, 3));
        tbl.push_back(mk(0, 'h7FFE, 1, 0, 0, 0, 'hFFFFCAFE, 3));

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        mem_clr = 1'b0;

        foreach (tbl[i]) begin
            rs = model(tbl[i].r);
            do_req(tbl[i].r, err, rd, lat, wr);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_wren_cnt", i), 32'(wr),
                32'(tbl[i].r.we && !tbl[i].err));
        end
        chk("mem_word0", mem[0], 32'hA5A5A5A5);
        chk("mem_word1", mem[1], 32'h12EE5678);
        chk("mem_word2", mem[2], 32'h80015A5A);

        // Reset lands in CAP of a byte store; the target must survive.
        rs = model(mkr(1, 'h0010, 2, 0, 32'h11223344));
        do_req(mkr(1, 'h0010, 2, 0, 32'h11223344), err, rd, lat, wr);
        @(negedge clk);
        drive(mkr(1, 'h0011, 0, 0, 32'h00000099));
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_rd_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("abort_cap_wren", 32'(mem_wren), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_ready", 32'(req_ready), 32'd1);
        chk("abort_rst_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("abort_post_wren", 32'(mem_wren), 32'd0);
            chk("abort_post_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_post_ready", 32'(req_ready), 32'd1);
        end
        chk("abort_mem_word4", mem[4], 32'h11223344);
        do_req(mkr(0, 'h0010, 2, 0, 0), err, rd, lat, wr);
        chk("abort_reload", rd, 32'h11223344);

        q.push_back(mkr(1, 'h0020, 2, 0, 32'hDEADBEEF));
        q.push_back(mkr(1, 'h0021, 0, 0, 32'h00000077));
        q.push_back(mkr(0, 'h0020, 2, 0, 0));
        q.push_back(mkr(0, 'h0021, 1, 0, 0));
        run_stream(q, "b2b");
        chk("b2b_mem_word8", mem[8], 32'hDEAD77EF);

        q.delete();
        for (int i = 0; i < 300; i++) q.push_back(rand_req());
        run_stream(q, "rnd");
        repeat (2) @(negedge clk);
        for (int w = 0; w < 16; w++)
            chk($sformatf("final_word%0d", w), mem[w], ref_mem[w]);
        chk("final_top_word", mem[NW-1], ref_mem[NW-1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that sits between the core's memory stage and `d_mem`, acting as the initiator of the data-memory port. Converts byte-addressed byte/halfword/word requests into word accesses on `d_mem`'s single-write-enable, 32-bit interface. Sub-word stores use read-modify-write. Loads are sign- or zero-extended, and misaligned requests are rejected without touching memory.

## Interface
- `ADDR_W`, 13: `d_mem` word-address width. The byte address is `ADDR_W+2` bits.

- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_req_valid` in 1: request valid.
- `o_req_ready` out 1: request accepted when both valid and ready are high.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_addr` in `ADDR_W+2`: byte address.
- `i_req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `i_req_unsigned` in 1: load zero-extends when set, otherwise sign-extends.
- `i_req_wdata` in 32: store data, right-aligned in the low bits.
- `o_rsp_valid` out 1: one-cycle completion pulse.
- `o_rsp_rdata` out 32: load result; 0 for stores and errors.
- `o_rsp_err` out 1: misaligned or illegal-size request.
- `o_mem_wren` out 1: to `d_mem` `i_wren`.
- `o_mem_addr` out `ADDR_W`: to `d_mem` `addr`, equal to `i_req_addr[ADDR_W+1:2]`.
- `o_mem_wdata` out 32: to `d_mem` `data_in`.
- `i_mem_rdata` in 32: from `d_mem` `data_out`. Valid the cycle after `o_mem_addr` is presented (synchronous read). A write commits on the edge where `o_mem_wren` = 1.

## Operation
- States:
  - IDLE
  - RD: read issued
  - CAP: read data returning
  - WR: write issued
  - RESP
- All outputs are registered. Reset values are 0 for every output, except `o_req_ready` = 1 (IDLE).
- In IDLE, `o_req_ready` = 1 and a handshake latches all request fields. `o_req_ready` = 0 in every other state.
- Error check at acceptance:
  - size 11 is illegal.
  - half with `addr[0]` = 1 is misaligned.
  - word with `addr[1:0]` ≠ 0 is misaligned.
  - On error: go IDLE→RESP with `o_rsp_err` = 1 and `o_rsp_rdata` = 0. `o_mem_wren` is never asserted.
- Load path: IDLE→RD→CAP→RESP.
  - CAP captures `i_mem_rdata` and extracts the addressed lane, little-endian:
    - byte lane `addr[1:0]` selects bits `[8k+7:8k]`.
    - half lane `addr[1]` selects bits `[16k+15:16k]`.
  - Extension: sign-extend from the lane MSB unless `i_req_unsigned`. Word loads pass through unchanged.
- Word store path: IDLE→WR→RESP.
  - In WR: `o_mem_wren` = 1, `o_mem_wdata` = `i_req_wdata`.
- Sub-word store path: IDLE→RD→CAP→WR→RESP.
  - CAP merges the low 8 or 16 bits of the store data into the addressed lane of the read word. Other lanes are preserved.
  - WR writes the merged word.
- RESP: `o_rsp_valid` = 1 for exactly one cycle, then go to IDLE. There is no response back-pressure.
- `o_mem_addr` holds the latched word address from RD/WR through RESP. It is don't-care in IDLE, but the implementation holds the last value.

## Timing
- Handshake on edge N (cycle 0). `o_rsp_valid` is high in the following cycle:
  - error: cycle 1
  - word store: cycle 2
  - load (any size): cycle 3
  - sub-word store: cycle 4
- `o_mem_wren` is high for exactly one cycle per store (the WR state) and never on loads or errors.
- Throughput: the next request is accepted one cycle after RESP (ready returns when the state returns to IDLE).
- `i_req_*` fields are ignored outside the handshake cycle. Changes during a transaction have no effect.
- Asynchronous reset mid-transaction:
  - Immediately go to IDLE and drop `o_mem_wren` and `o_rsp_valid`. No response is issued.
  - If reset asserts before WR, memory is unmodified.
- Address wrap: the top word address (`2^ADDR_W - 1`) is a legal access with no wrap logic. Bits above `ADDR_W+1` do not exist.

## Test plan
- Word store then load: store `0xA5A5A5A5` at byte addr 0x0000, then load word at 0x0000.
  - Store: `wren` pulses once in cycle 1 with addr 0 and rsp in cycle 2.
  - Load: rdata `0xA5A5A5A5`, rsp in cycle 3.
- Byte RMW: preload word addr 1 with `0x12345678`, then store byte `0xEE` at byte addr 0x0006.
  - Memory word 1 becomes `0x12EE5678`.
  - Loads at 0x0006: signed → `0xFFFFFFEE`; unsigned → `0x000000EE`.
- Half RMW: with word 2 = `0x5A5A5A5A`, store half `0x8001` at 0x000A.
  - Word becomes `0x80015A5A`.
  - Signed half load at 0x000A → `0xFFFF8001`.
- Errors:
  - Word load at 0x0002 → err=1 in cycle 1, rdata 0, no `wren`.
  - Half store at 0x0003 → err=1, memory unchanged.
  - Size 11 → err=1.
- Reset mid-RMW: assert `i_rst_n` = 0 during CAP of a byte store.
  - `wren` is never asserted and the target word is unchanged.
  - No rsp is issued, and `o_req_ready` = 1 after release.
- Back-to-back: hold `i_req_valid` high with four mixed requests.
  - Exactly four rsp pulses, in order, with the latencies above.
  - `ready` is high only in IDLE cycles.
